// File: rtl/data_mux_pkg.sv
// Shared types and defaults for the data mux scheduler.
// The enum encodes the turn state; the localparams are the default widths.
package data_mux_pkg;
  localparam int N_INPUTS_DEF    = 2;
  localparam int SEL_WIDTH_DEF   = 4;
  localparam int DWELL_WIDTH_DEF = 16;
  localparam int GAP_WIDTH       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_e;
endpackage

// File: rtl/rr_next_select.sv
// Round-robin search for the next set mask bit strictly above cur_sel, with wrap-around.
// wrap is set when the found index is at or below cur_sel.
module rr_next_select #(
  parameter int N_INPUTS  = 2,
  parameter int SEL_WIDTH = 4
) (
  input  logic [N_INPUTS-1:0]  mask,
  input  logic [SEL_WIDTH-1:0] cur_sel,
  output logic [SEL_WIDTH-1:0] next_sel,
  output logic                 wrap
);
  always_comb begin
    int                  idx;
    logic                found;
    logic [N_INPUTS-1:0] probe;
    next_sel = cur_sel;
    wrap     = 1'b0;
    found    = 1'b0;
    idx      = 0;
    probe    = '0;
    // k runs to N_INPUTS so a lone set bit finds itself and reports a wrap
    for (int k = 1; k <= N_INPUTS; k++) begin
      idx = int'(cur_sel) + k;
      if (idx >= N_INPUTS) idx = idx - N_INPUTS;
      probe = mask >> idx;
      if (!found && probe[0]) begin
        found    = 1'b1;
        next_sel = SEL_WIDTH'(idx);
        wrap     = (idx <= int'(cur_sel));
      end
    end
  end
endmodule

// File: rtl/data_mux_scheduler.sv
// Dwell/gap round-robin scheduler driving a data mux select and idle insertion.
// Fast commands: linkReset forces IDLE and clears rotations; orbitSync restarts on the lowest input.
module data_mux_scheduler
  import data_mux_pkg::*;
#(
  parameter int N_INPUTS    = N_INPUTS_DEF,
  parameter int SEL_WIDTH   = SEL_WIDTH_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [N_INPUTS-1:0]    input_mask,
  input  logic [DWELL_WIDTH-1:0] dwell_words,
  input  logic [GAP_WIDTH-1:0]   gap_words,
  input  logic                   tvalid_out,
  input  logic                   tready_out,
  input  logic                   fc_orbitSync,
  input  logic                   fc_linkReset,
  output logic [SEL_WIDTH-1:0]   output_select,
  output logic                   insert_idle,
  output logic                   busy,
  output logic [DWELL_WIDTH-1:0] rotation_count
);
  sched_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic                   idle_q, idle_d;
  logic                   busy_q, busy_d;
  logic [DWELL_WIDTH-1:0] rot_q, rot_d;
  logic [DWELL_WIDTH-1:0] beat_q, beat_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;

  logic [SEL_WIDTH-1:0]   nxt_sel, low_sel;
  logic                   nxt_wrap;
  logic [N_INPUTS-1:0]    cur_probe;
  logic                   cur_live, beat, run_ok, turn_done, gap_done;
  logic [DWELL_WIDTH-1:0] dwell_eff, beat_inc;

  rr_next_select #(.N_INPUTS(N_INPUTS), .SEL_WIDTH(SEL_WIDTH)) u_next (
    .mask     (input_mask),
    .cur_sel  (sel_q),
    .next_sel (nxt_sel),
    .wrap     (nxt_wrap)
  );

  always_comb begin
    low_sel = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--)
      if (input_mask[i]) low_sel = SEL_WIDTH'(i);
  end

  assign cur_probe = input_mask >> sel_q;
  assign cur_live  = cur_probe[0];
  assign beat      = tvalid_out & tready_out;
  assign run_ok    = enable & (|input_mask);
  assign dwell_eff = (dwell_words == '0) ? DWELL_WIDTH'(1) : dwell_words;
  assign beat_inc  = beat_q + DWELL_WIDTH'(1);
  // A dropped mask bit ends the turn just like a completed dwell
  assign turn_done = ~cur_live | (beat & (beat_inc == dwell_eff));
  assign gap_done  = ({1'b0, gap_q} + 9'd1) >= {1'b0, gap_words};

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idle_d  = idle_q;
    rot_d   = rot_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    if (fc_linkReset) begin
      state_d = ST_IDLE;
      sel_d   = '0;
      idle_d  = 1'b0;
      rot_d   = '0;
      beat_d  = '0;
      gap_d   = '0;
    end else if (fc_orbitSync && state_q != ST_IDLE) begin
      state_d = (|input_mask) ? ST_DWELL : ST_IDLE;
      if (|input_mask) sel_d = low_sel;
      idle_d  = 1'b0;
      beat_d  = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_ok) begin
            state_d = ST_DWELL;
            sel_d   = low_sel;
            beat_d  = '0;
          end
        end
        ST_DWELL: begin
          if (beat) beat_d = beat_inc;
          if (turn_done) begin
            beat_d = '0;
            if (!run_ok) begin
              state_d = ST_IDLE;
            end else if (gap_words != '0) begin
              state_d = ST_GAP;
              gap_d   = '0;
              idle_d  = 1'b1;
            end else begin
              sel_d = nxt_sel;
              rot_d = rot_q + DWELL_WIDTH'(nxt_wrap);
            end
          end
        end
        ST_GAP: begin
          gap_d = gap_q + GAP_WIDTH'(1);
          if (gap_done) begin
            gap_d  = '0;
            idle_d = 1'b0;
            beat_d = '0;
            if (!run_ok) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DWELL;
              sel_d   = nxt_sel;
              rot_d   = rot_q + DWELL_WIDTH'(nxt_wrap);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          idle_d  = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      idle_q  <= 1'b0;
      busy_q  <= 1'b0;
      rot_q   <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idle_q  <= idle_d;
      busy_q  <= busy_d;
      rot_q   <= rot_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
    end
  end

  assign output_select  = sel_q;
  assign insert_idle    = idle_q;
  assign busy           = busy_q;
  assign rotation_count = rot_q;
endmodule

// File: tb/tb_data_mux_scheduler.sv
// Directed bench for data_mux_scheduler with hand-computed per-cycle expectations.
module tb_data_mux_scheduler;
  localparam int NI = 4;
  localparam int SW = 4;
  localparam int DW = 16;

  logic          clk, aresetn, enable, tvalid_out, tready_out, fc_orbitSync, fc_linkReset;
  logic [NI-1:0] input_mask;
  logic [DW-1:0] dwell_words;
  logic [7:0]    gap_words;
  logic [SW-1:0] output_select;
  logic          insert_idle, busy;
  logic [DW-1:0] rotation_count;

  int n_chk  = 0;
  int n_pass = 0;

  int sel_a [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
  int idle_a[13] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0};
  int selb_a[9]  = '{1, 1, 3, 3, 1, 1, 3, 3, 1};
  int rotb_a[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
  int tv_a  [5]  = '{1, 0, 1, 0, 1};

  data_mux_scheduler #(.N_INPUTS(NI), .SEL_WIDTH(SW), .DWELL_WIDTH(DW)) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .enable         (enable),
    .input_mask     (input_mask),
    .dwell_words    (dwell_words),
    .gap_words      (gap_words),
    .tvalid_out     (tvalid_out),
    .tready_out     (tready_out),
    .fc_orbitSync   (fc_orbitSync),
    .fc_linkReset   (fc_linkReset),
    .output_select  (output_select),
    .insert_idle    (insert_idle),
    .busy           (busy),
    .rotation_count (rotation_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lreset();
    enable       = 1'b0;
    fc_linkReset = 1'b1;
    step();
    chk("lrst_busy", 32'(busy), 0);
    chk("lrst_rot", 32'(rotation_count), 0);
    fc_linkReset = 1'b0;
  endtask

  initial begin
    clk = 0; aresetn = 0; enable = 0; input_mask = '0; dwell_words = '0; gap_words = '0;
    tvalid_out = 0; tready_out = 0; fc_orbitSync = 0; fc_linkReset = 0;
    #12;
    chk("rst_sel", 32'(output_select), 0);
    chk("rst_idle", 32'(insert_idle), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rot", 32'(rotation_count), 0);
    aresetn = 1;
    step();

    // enable with an empty mask must stay idle
    enable = 1;
    step();
    chk("mask0_busy", 32'(busy), 0);

    // two inputs, dwell 4, gap 2
    input_mask = 4'b0011; dwell_words = 4; gap_words = 2; tvalid_out = 1; tready_out = 1;
    for (int k = 0; k < 13; k++) begin
      step();
      chk("a_sel", 32'(output_select), 32'(sel_a[k]));
      chk("a_idle", 32'(insert_idle), 32'(idle_a[k]));
      chk("a_rot", 32'(rotation_count), (k == 12) ? 32'd1 : 32'd0);
    end
    lreset();

    // sparse mask, no gap
    input_mask = 4'b1010; dwell_words = 2; gap_words = 0; enable = 1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("b_sel", 32'(output_select), 32'(selb_a[k]));
      chk("b_rot", 32'(rotation_count), 32'(rotb_a[k]));
      chk("b_idle", 32'(insert_idle), 0);
    end
    lreset();

    // only beats count; single input reselects itself and rotates
    input_mask = 4'b0001; dwell_words = 3; gap_words = 0; tvalid_out = 0; enable = 1;
    step();
    chk("c_busy", 32'(busy), 1);
    for (int k = 0; k < 5; k++) begin
      tvalid_out = tv_a[k][0];
      step();
      chk("c_rot", 32'(rotation_count), (k == 4) ? 32'd1 : 32'd0);
    end
    tvalid_out = 1;
    lreset();

    // orbitSync mid-dwell, then linkReset+orbitSync together
    input_mask = 4'b0011; dwell_words = 4; gap_words = 0; enable = 1;
    step(5);
    chk("d_sel1", 32'(output_select), 1);
    step();
    fc_orbitSync = 1;
    step();
    fc_orbitSync = 0;
    chk("d_os_sel", 32'(output_select), 0);
    chk("d_os_idle", 32'(insert_idle), 0);
    chk("d_os_rot", 32'(rotation_count), 0);
    step(3);
    chk("d_cnt_clr", 32'(output_select), 0);
    step();
    chk("d_cnt_end", 32'(output_select), 1);
    step(4);
    chk("d_rot1", 32'(rotation_count), 1);
    fc_orbitSync = 1; fc_linkReset = 1;
    step();
    chk("d_lr_busy", 32'(busy), 0);
    chk("d_lr_sel", 32'(output_select), 0);
    chk("d_lr_rot", 32'(rotation_count), 0);
    chk("d_lr_idle", 32'(insert_idle), 0);
    fc_orbitSync = 0; fc_linkReset = 0; enable = 0;
    step();

    // current mask bit drops mid-dwell, then enable drops
    input_mask = 4'b0011; dwell_words = 4; gap_words = 2; enable = 1;
    step();
    input_mask = 4'b0010;
    step();
    chk("e_gap_idle", 32'(insert_idle), 1);
    chk("e_gap_sel", 32'(output_select), 0);
    step();
    chk("e_gap2_idle", 32'(insert_idle), 1);
    step();
    chk("e_sel1", 32'(output_select), 1);
    chk("e_idle0", 32'(insert_idle), 0);
    enable = 0;
    step(3);
    chk("e_busy_hold", 32'(busy), 1);
    step();
    chk("e_busy_off", 32'(busy), 0);
    chk("e_sel_keep", 32'(output_select), 1);

    // dwell of zero behaves as one
    input_mask = 4'b0011; dwell_words = 0; gap_words = 0; enable = 1;
    step();
    chk("z_sel0", 32'(output_select), 0);
    step();
    chk("z_sel1", 32'(output_select), 1);
    step();
    chk("z_rot", 32'(rotation_count), 1);
    lreset();

    // async reset in the middle of a gap
    input_mask = 4'b0011; dwell_words = 1; gap_words = 3; enable = 1;
    step(10);
    chk("f_pre_idle", 32'(insert_idle), 1);
    chk("f_pre_rot", 32'(rotation_count), 1);
    aresetn = 0;
    #1;
    chk("f_rst_idle", 32'(insert_idle), 0);
    chk("f_rst_busy", 32'(busy), 0);
    chk("f_rst_rot", 32'(rotation_count), 0);
    chk("f_rst_sel", 32'(output_select), 0);
    input_mask = 4'b0001;
    #2;
    aresetn = 1;
    step();
    chk("f_first_busy", 32'(busy), 1);
    chk("f_first_sel", 32'(output_select), 0);
    chk("f_first_idle", 32'(insert_idle), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
